// File: rtl/cp0_vic.sv
// CP0-style vectored interrupt controller.
// Holds Status, Cause, EPC and a nesting depth counter, plus a save stack of
// {Status, EPC} frames. Decides each cycle whether to take an exception, an
// eret, or an interrupt, and steers the next PC accordingly.
module cp0_vic #(
   parameter int          N_IRQ      = 8,
   parameter int          NEST_DEPTH = 4,
   parameter logic [31:0] EXC_BASE   = 32'h0000_0040,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0020
) (
   input  logic             Clk,
   input  logic             Clrn,
   input  logic [N_IRQ-1:0] intr,
   input  logic             exc_ovf,
   input  logic             exc_sys,
   input  logic             eret,
   input  logic [31:0]      cur_pc,
   input  logic [31:0]      npc,
   input  logic             c0_we,
   input  logic [4:0]       c0_addr,
   input  logic [31:0]      c0_wdata,
   output logic [31:0]      c0_rdata,
   output logic [31:0]      pc_out,
   output logic             inta,
   output logic [3:0]       inta_id
);

   localparam int         SW        = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
   localparam logic [3:0] DEPTH_MAX = 4'(NEST_DEPTH);

   // Architectural registers
   logic             ie_reg;
   logic [N_IRQ-1:0] im_reg;
   logic [4:0]       exc_code_reg;
   logic [N_IRQ-1:0] pend_reg;
   logic [N_IRQ-1:0] pend_next;
   logic             novf_reg;
   logic [31:0]      epc_reg;
   logic [3:0]       depth_reg;

   // Save stack, one frame per nesting level
   logic             stk_ie_reg  [NEST_DEPTH];
   logic [N_IRQ-1:0] stk_im_reg  [NEST_DEPTH];
   logic [31:0]      stk_epc_reg [NEST_DEPTH];

   // Event decode
   logic             exc_any;
   logic             eret_go;
   logic             can_push;
   logic             irq_go;
   logic             do_push;
   logic [N_IRQ-1:0] masked;
   logic [3:0]       irq_id;
   logic [3:0]       depth_dec;
   logic [SW-1:0]    push_idx;
   logic [SW-1:0]    pop_idx;
   logic [31:0]      vec_addr;
   logic             status_busy;
   logic             cause_busy;
   logic             epc_busy;
   logic             wr_status;
   logic             wr_cause;
   logic             wr_epc;
   logic [N_IRQ-1:0] ack_clr;
   logic [N_IRQ-1:0] w1c_clr;
   logic             wdata_unused;

   // Only some mtc0 data bits land in a register; fold the rest away
   assign wdata_unused = ^c0_wdata;

   assign exc_any   = exc_ovf | exc_sys;
   assign eret_go   = eret & ~exc_any;
   assign can_push  = (depth_reg < DEPTH_MAX);
   assign masked    = pend_reg & im_reg;
   assign irq_go    = ie_reg & (|masked) & can_push & ~exc_any & ~eret;
   assign do_push   = irq_go | (exc_any & can_push);
   assign depth_dec = depth_reg - 4'd1;
   assign push_idx  = depth_reg[SW-1:0];
   assign pop_idx   = depth_dec[SW-1:0];
   assign vec_addr  = EXC_BASE + VEC_STRIDE * ({28'd0, irq_id} + 32'd1);

   // An mtc0 is dropped when the same cycle's event already updates that register
   assign status_busy = exc_any | eret_go | irq_go;
   assign cause_busy  = exc_any | irq_go;
   assign epc_busy    = exc_any | irq_go | (eret_go & (depth_reg != 4'd0));
   assign wr_status   = c0_we & (c0_addr == 5'd12) & ~status_busy;
   assign wr_cause    = c0_we & (c0_addr == 5'd13) & ~cause_busy;
   assign wr_epc      = c0_we & (c0_addr == 5'd14) & ~epc_busy;

   // Lowest-index pending and enabled line wins
   always_comb begin
      irq_id = 4'd0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (masked[i]) irq_id = 4'(i);
      end
   end

   // Per-line pending update: new requests beat acknowledge and W1C clears
   generate
      for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
         assign ack_clr[gi]   = irq_go & (irq_id == 4'(gi));
         assign w1c_clr[gi]   = wr_cause & c0_wdata[8 + gi];
         assign pend_next[gi] = intr[gi] | (pend_reg[gi] & ~(ack_clr[gi] | w1c_clr[gi]));
      end
   endgenerate

   // Next-PC steering and acknowledge; reset forces the idle values
   always_comb begin
      pc_out  = npc;
      inta    = 1'b0;
      inta_id = 4'd0;
      if (!Clrn) begin
         if (exc_any) begin
            pc_out = EXC_BASE;
         end else if (eret) begin
            pc_out = epc_reg;
         end else if (irq_go) begin
            pc_out  = vec_addr;
            inta    = 1'b1;
            inta_id = irq_id;
         end
      end
   end

   // mfc0 read mux
   always_comb begin
      c0_rdata = 32'd0;
      case (c0_addr)
         5'd12: begin
            c0_rdata[0]          = ie_reg;
            c0_rdata[8 +: N_IRQ] = im_reg;
         end
         5'd13: begin
            c0_rdata[6:2]        = exc_code_reg;
            c0_rdata[8 +: N_IRQ] = pend_reg;
            c0_rdata[31]         = novf_reg;
         end
         5'd14:   c0_rdata = epc_reg;
         5'd15:   c0_rdata[3:0] = depth_reg;
         default: c0_rdata = 32'd0;
      endcase
   end

   // Stack frames: written on push at the current depth, cleared by reset
   generate
      for (genvar gi = 0; gi < NEST_DEPTH; gi++) begin : g_stk
         always_ff @(posedge Clk) begin
            if (Clrn) begin
               stk_ie_reg[gi]  <= 1'b0;
               stk_im_reg[gi]  <= '0;
               stk_epc_reg[gi] <= 32'd0;
            end else if (do_push && (push_idx == SW'(gi))) begin
               stk_ie_reg[gi]  <= ie_reg;
               stk_im_reg[gi]  <= im_reg;
               stk_epc_reg[gi] <= epc_reg;
            end
         end
      end
   endgenerate

   // Register update: exception > eret > interrupt, then surviving mtc0 writes
   always_ff @(posedge Clk) begin
      if (Clrn) begin
         ie_reg       <= 1'b0;
         im_reg       <= '0;
         exc_code_reg <= 5'd0;
         pend_reg     <= '0;
         novf_reg     <= 1'b0;
         epc_reg      <= 32'd0;
         depth_reg    <= 4'd0;
      end else begin
         pend_reg <= pend_next;
         if (exc_any) begin
            exc_code_reg <= exc_ovf ? 5'd12 : 5'd8;
            epc_reg      <= cur_pc;
            ie_reg       <= 1'b0;
            if (can_push) depth_reg <= depth_reg + 4'd1;
            else          novf_reg  <= 1'b1;
         end else if (eret) begin
            if (depth_reg != 4'd0) begin
               ie_reg    <= stk_ie_reg[pop_idx];
               im_reg    <= stk_im_reg[pop_idx];
               epc_reg   <= stk_epc_reg[pop_idx];
               depth_reg <= depth_dec;
            end else begin
               ie_reg <= 1'b1;
            end
         end else if (irq_go) begin
            depth_reg    <= depth_reg + 4'd1;
            epc_reg      <= npc;
            ie_reg       <= 1'b0;
            exc_code_reg <= 5'd0;
         end
         if (wr_status) begin
            ie_reg <= c0_wdata[0];
            im_reg <= c0_wdata[8 +: N_IRQ];
         end
         if (wr_cause) novf_reg <= c0_wdata[31];
         if (wr_epc)   epc_reg  <= c0_wdata;
      end
   end

endmodule
